per_bus_arb: RTL
================

// Module: per_bus_arb
// PURPOSE
//  Two-master arbiter for the peripheral register bus (addr/wdata/rdata/size/rd/wr) feeding per_gpio
//  and sibling per_* slaves. Master 0 = CPU data port, master 1 = debug/DMA port. Round-robin grant,
//  per-master request/ready handshake, registered bus strobes, read data captured one cycle after rd.
// PARAMETERS
//  ADDR_W   16  peripheral address width
//  DATA_W   32  data width
// PORTS
//  clk_i          in   1       clock
//  reset_n_i      in   1       asynchronous active-low reset
//  mN_addr_i      in   ADDR_W  master N address (N = 0,1)
//  mN_wdata_i     in   DATA_W  master N write data
//  mN_size_i      in   2       master N access size (passed through)
//  mN_rd_i        in   1       master N read request (level, held until ready)
//  mN_wr_i        in   1       master N write request (level, held until ready)
//  mN_ready_o     out  1       one-cycle completion pulse to master N
//  mN_rdata_o     out  DATA_W  read data, valid while mN_ready_o=1 for a read
//  mN_lock_i      in   1       bus lock request (only with PER_BUS_ARB_LOCK_EN)
//  per_addr_o     out  ADDR_W  slave address (registered)
//  per_wdata_o    out  DATA_W  slave write data (registered)
//  per_size_o     out  2       slave size (registered)
//  per_rd_o       out  1       slave read strobe, one cycle
//  per_wr_o       out  1       slave write strobe, one cycle
//  per_rdata_i    in   DATA_W  slave read data, valid the cycle after per_rd_o
//  owner_o        out  1       index of last/current granted master
//  busy_o         out  1       1 when state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, per_rd_o/per_wr_o/mN_ready_o/busy_o=0,
//    per_addr_o/wdata_o/size_o=0, mN_rdata_o=0, owner_o=1 (so master 0 wins first tie).
//    Reset mid-access aborts immediately; strobes drop asynchronously, no ready is issued.
//  - FSM IDLE -> ACCESS -> (write) IDLE | (read) RDATA -> IDLE.
//  - IDLE: request = rd|wr. If one master requests, grant it. If both, grant the master != owner_o.
//    On grant: latch addr/wdata/size into per_* regs, set owner_o, go ACCESS. rd&wr both high = write.
//  - ACCESS (1 cycle): per_wr_o or per_rd_o = 1. Write: mN_ready_o=1 this cycle, next IDLE.
//    Read: next RDATA.
//  - RDATA (1 cycle): mN_rdata_o <= per_rdata_i is presented combinationally, mN_ready_o=1, next IDLE.
//  - Latency from request sampled in IDLE (cycle N): write strobe+ready N+1; read strobe N+1,
//    ready+data N+2. Throughput: write 1 per 2 cycles, read 1 per 3 cycles.
//  - Master must hold rd/wr/addr/wdata/size stable until ready; request is sampled in IDLE only.
//    Dropping a request after grant does not cancel it; the access completes and ready pulses.
//  - Non-granted master's ready stays 0; its rdata_o holds its last value.
//  - Back-to-back: a master holding request after ready is re-arbitrated in IDLE; with both
//    requesting, grants alternate 0,1,0,1.
// CONFIGURATION
//  PER_BUS_ARB_LOCK_EN defined: mN_lock_i exist. If granted master has lock_i=1 at grant, it
//    stays owner: in IDLE, only owner's requests are granted until its lock_i=0 at an IDLE cycle
//    (read-modify-write on GPIO regs without interleaving). Lock ignored on non-owner.
//  Undefined: no lock ports; pure round-robin as above.
// STRUCTURE
//  per_bus_arb_pkg: state encoding (IDLE/ACCESS/RDATA), master index localparams, size codes.
//  Sub-module per_bus_arb_rr: 2-way round-robin picker (req[1:0], last -> gnt, gnt_idx); combinational.
// TESTING
//  1 Reset: hold reset_n_i=0 mid-ACCESS -> per_wr_o=0 immediately, no ready, owner_o=1 after.
//  2 m0 wr addr 0x0000 data 0xA5A5_0000 -> per_wr_o at N+1, m0_ready_o at N+1, per_gpio out=0xA5A50000.
//  3 m1 rd addr 0x0010, gpio_in=0x1234_5678 -> per_rd_o N+1, m1_ready_o+m1_rdata_o=0x12345678 at N+2.
//  4 Both hold writes (m0 to 0x0004 0x1, m1 to 0x0004 0x2) for 4 grants -> order m0,m1,m0,m1; out=0x3.
//  5 m0 drops wr the cycle after grant -> access still issued, m0_ready_o pulses once, m1 unaffected.
//  6 LOCK_EN: m1 lock=1, rd 0x0000 then wr 0x0000 while m0 requests -> m1 gets both; m0 granted
//    only after m1 lock=0; without macro m0 interleaves between them.

Source files
------------

// File: rtl/per_bus_arb_pkg.sv
// Shared constants for the two-master peripheral bus arbiter: FSM encoding, master indices,
// access size codes and the round-robin pick rule.
package per_bus_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RDATA  = 2'd2;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DBG = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // On a tie the master that did not own the bus last wins; a lone requester always wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/per_bus_arb_rr.sv
// Combinational 2-way round-robin picker used by per_bus_arb.
module per_bus_arb_rr
    import per_bus_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    assign gnt_idx_o = rr_pick(req_i, last_i);
    assign gnt_o     = (|req_i) ? ((gnt_idx_o == MST_DBG) ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/per_bus_arb.sv
// Two-master round-robin arbiter for the peripheral register bus with registered strobes.
// Optional bus lock for read-modify-write sequences: define PER_BUS_ARB_LOCK_EN.
module per_bus_arb
    import per_bus_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [1:0]        m0_size_i,
    input  logic              m0_rd_i,
    input  logic              m0_wr_i,
    output logic              m0_ready_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [1:0]        m1_size_i,
    input  logic              m1_rd_i,
    input  logic              m1_wr_i,
    output logic              m1_ready_o,
    output logic [DATA_W-1:0] m1_rdata_o,
`ifdef PER_BUS_ARB_LOCK_EN
    input  logic              m0_lock_i,
    input  logic              m1_lock_i,
`endif
    output logic [ADDR_W-1:0] per_addr_o,
    output logic [DATA_W-1:0] per_wdata_o,
    output logic [1:0]        per_size_o,
    output logic              per_rd_o,
    output logic              per_wr_o,
    input  logic [DATA_W-1:0] per_rdata_i,
    output logic              owner_o,
    output logic              busy_o
);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic [1:0] req_raw, req, gnt;
    logic       gnt_any, sel, sel_rd, sel_wr;

    assign req_raw = {m1_rd_i | m1_wr_i, m0_rd_i | m0_wr_i};

`ifdef PER_BUS_ARB_LOCK_EN
    logic lock_q, lock_d, lock_act;

    // Lock only counts while the owner keeps asserting it; a dropped lock frees the bus this cycle.
    assign lock_act = lock_q & (owner_q ? m1_lock_i : m0_lock_i);
    assign req      = lock_act ? (req_raw & (owner_q ? 2'b10 : 2'b01)) : req_raw;

    always_comb begin
        lock_d = lock_q;
        if (state_q == ST_IDLE) begin
            lock_d = gnt_any ? (sel ? m1_lock_i : m0_lock_i) : lock_act;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) lock_q <= 1'b0;
        else            lock_q <= lock_d;
    end
`else
    assign req = req_raw;
`endif

    per_bus_arb_rr u_rr (
        .req_i     (req),
        .last_i    (owner_q),
        .gnt_o     (gnt),
        .gnt_idx_o (sel)
    );

    assign gnt_any = |gnt;
    assign sel_wr  = sel ? m1_wr_i : m0_wr_i;
    assign sel_rd  = sel ? m1_rd_i : m0_rd_i;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    owner_d = sel;
                    addr_d  = sel ? m1_addr_i  : m0_addr_i;
                    wdata_d = sel ? m1_wdata_i : m0_wdata_i;
                    size_d  = sel ? m1_size_i  : m0_size_i;
                    wr_d    = sel_wr;
                    rd_d    = sel_rd & ~sel_wr;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = rd_q ? ST_RDATA : ST_IDLE;
            ST_RDATA:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            owner_q <= MST_DBG;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Each master keeps the last word it read so a non-granted master's rdata_o stays put.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == ST_RDATA) begin
            if (owner_q) rdata1_q <= per_rdata_i;
            else         rdata0_q <= per_rdata_i;
        end
    end

    logic rdata_phase, done;

    assign rdata_phase = (state_q == ST_RDATA);
    assign done        = wr_q | rdata_phase;

    assign m0_ready_o  = done & ~owner_q;
    assign m1_ready_o  = done & owner_q;
    assign m0_rdata_o  = (rdata_phase & ~owner_q) ? per_rdata_i : rdata0_q;
    assign m1_rdata_o  = (rdata_phase & owner_q)  ? per_rdata_i : rdata1_q;

    assign per_addr_o  = addr_q;
    assign per_wdata_o = wdata_q;
    assign per_size_o  = size_q;
    assign per_rd_o    = rd_q;
    assign per_wr_o    = wr_q;
    assign owner_o     = owner_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
